layer1_serializer: RTL and testbench
====================================

LAYER1_SERIALIZER -- requirements
Module: layer1_serializer

Interface
REQ-001 Parameter CHANNELS, default 32: channel words captured per input vector.
REQ-002 Parameter DATA_BITS, default 32: width of each channel word.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  synchronous, active-high reset (1 = reset), sampled on clk.
REQ-005 valid_in  input  1  one-cycle strobe; marks a new pooled vector on data_in_k.
REQ-006 data_in_k (k=1..CHANNELS)  input  DATA_BITS each  pooled channel words; data_in_1 is channel 0.
REQ-007 ready_in  input  1  downstream accepts the current beat.
REQ-008 data_out  output  DATA_BITS  current serialized channel word.
REQ-009 ch_idx  output  5  channel index of data_out, 0..CHANNELS-1.
REQ-010 valid_out  output  1  data_out and ch_idx valid.
REQ-011 overflow  output  1  sticky; set when a vector is dropped.
REQ-012 last_out  output  1  present only with SER_LAST_EN; high on the final channel beat.

Function
REQ-013 Two-entry vector buffer (slot 0/1, ping-pong); each slot holds CHANNELS words; occupancy count 0..2.
REQ-014 Capture: on valid_in with count<2, all CHANNELS words written to write slot in that cycle; write pointer toggles.
REQ-015 Beat handshake: a beat completes when valid_out && ready_in; ch_idx increments only on a completed beat.
REQ-016 While valid_out=1 and ready_in=0, data_out, ch_idx, valid_out (and last_out) SHALL hold stable.
REQ-017 FSM IDLE: valid_out=0; go STREAM when count>0 (registered), ch_idx=0.
REQ-018 FSM STREAM: valid_out=1; on completed beat with ch_idx=CHANNELS-1: free read slot, ch_idx=0, toggle read pointer; stay STREAM if other slot full, else IDLE.
REQ-019 Latency: valid_in at cycle t into empty buffer -> valid_out=1, ch_idx=0, data_out=data_in_1 at cycle t+1.
REQ-020 Back-to-back vectors: no bubble between channel CHANNELS-1 of one vector and channel 0 of the next when ready_in held high.
REQ-021 Simultaneous capture and final-beat free with count=2: freed slot SHALL accept the capture; count stays 2; overflow not set.
REQ-022 valid_in with count=2 and no same-cycle free: vector dropped, buffer unchanged, overflow set to 1 (sticky until reset).
REQ-023 Data passes unmodified; no arithmetic on words; ch_idx wraps CHANNELS-1 -> 0 only per REQ-018.
REQ-024 Sustained throughput: one vector per CHANNELS cycles with ready_in=1; faster valid_in rate overflows per REQ-022.

Reset
REQ-025 rst_n=1 at a clk edge: FSM IDLE, count=0, both pointers 0, ch_idx=0, valid_out=0, data_out=0, overflow=0, last_out=0.
REQ-026 Reset mid-stream discards all buffered vectors; valid_in coincident with reset is ignored.
REQ-027 Buffer storage contents need not be reset.

Configuration
REQ-028 Macro SER_LAST_EN defined: last_out port exists; last_out = valid_out && ch_idx==CHANNELS-1.
REQ-029 SER_LAST_EN undefined: last_out port and logic absent; all other behaviour identical.

Verification
REQ-030 Single vector: data_in_k=k*16'h0101, valid_in once, ready_in=1 -> 32 consecutive beats ch_idx 0..31, data_out=0x0101..0x2020, then valid_out=0.
REQ-031 Stall: ready_in=0 at ch_idx=5 for 7 cycles -> data_out/ch_idx frozen at channel 5, no beat lost or duplicated.
REQ-032 Back-to-back: two vectors 1 cycle apart, ready_in=1 -> 64 contiguous beats, ch_idx 0..31 twice, overflow=0.
REQ-033 Overflow: three vectors on cycles 0,1,2, ready_in=0 -> third dropped, overflow=1; release ready_in -> first two vectors delivered intact.
REQ-034 Same-cycle free: count=2, valid_in on final beat of slot -> new vector streamed third, overflow=0.
REQ-035 Reset mid-stream at ch_idx=10 -> next cycle valid_out=0, ch_idx=0, overflow=0; with SER_LAST_EN, last_out high only at ch_idx=31.

Source files
------------

// File: rtl/layer1_serializer_if.sv
// layer1_serializer_if: vector-in / word-stream-out bundle (master drives valid_in, data_in, ready_in; slave drives data_out, ch_idx, valid_out, overflow; last_out with SER_LAST_EN)
interface layer1_serializer_if #(
  parameter int CHANNELS  = 32,
  parameter int DATA_BITS = 32
);
  logic                                valid_in;
  logic [CHANNELS-1:0][DATA_BITS-1:0]  data_in;
  logic                                ready_in;
  logic [DATA_BITS-1:0]                data_out;
  logic [4:0]                          ch_idx;
  logic                                valid_out;
  logic                                overflow;
`ifdef SER_LAST_EN
  logic                                last_out;
  modport master (output valid_in, data_in, ready_in, input data_out, ch_idx, valid_out, overflow, last_out);
  modport slave  (input valid_in, data_in, ready_in, output data_out, ch_idx, valid_out, overflow, last_out);
`else
  modport master (output valid_in, data_in, ready_in, input data_out, ch_idx, valid_out, overflow);
  modport slave  (input valid_in, data_in, ready_in, output data_out, ch_idx, valid_out, overflow);
`endif
endinterface

// File: rtl/layer1_serializer.sv
// layer1_serializer: ping-pong buffers CHANNELS-word vectors and streams them one word per ready beat (ports clk, rst_n active-high sync reset, bus slave modport; SER_LAST_EN adds last_out)
module layer1_serializer #(
  parameter int CHANNELS  = 32,
  parameter int DATA_BITS = 32
) (
  input logic                clk,
  input logic                rst_n,
  layer1_serializer_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [4:0] LAST = 5'(CHANNELS - 1);
  state_t state_q, state_d;
  logic [1:0] count_q, count_d;
  logic wr_q, wr_d, rd_q, rd_d, ovf_q, ovf_d;
  logic [4:0] ch_q, ch_d;
  logic last_beat, free, accept;
  logic [CHANNELS-1:0][DATA_BITS-1:0] mem [2];
  always_comb begin
    last_beat = ch_q == LAST;
    free      = state_q == STREAM && bus.ready_in && last_beat;
    accept    = bus.valid_in && (count_q != 2'd2 || free);
    count_d   = count_q + 2'(accept) - 2'(free);
    wr_d      = wr_q ^ accept;
    rd_d      = rd_q ^ free;
    ovf_d     = ovf_q | (bus.valid_in & ~accept);
    ch_d      = state_q == STREAM && bus.ready_in ? (last_beat ? 5'd0 : ch_q + 5'd1) : ch_q;
    state_d   = count_d != 2'd0 ? STREAM : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ch_q    <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ch_q    <= ch_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n && accept) mem[wr_q] <= bus.data_in;
  assign bus.valid_out = state_q == STREAM;
  assign bus.ch_idx    = ch_q;
  assign bus.data_out  = bus.valid_out ? mem[rd_q][ch_q] : '0;
  assign bus.overflow  = ovf_q;
`ifdef SER_LAST_EN
  assign bus.last_out  = bus.valid_out && last_beat;
`endif
endmodule

// File: tb/tb_layer1_serializer.sv
// tb_layer1_serializer: table vectors, directed corner sequences and random traffic against a queue-based reference
module tb_layer1_serializer;
  localparam int CH = 32;
  localparam int DB = 32;
  typedef logic [CH-1:0][DB-1:0] vec_t;
  typedef struct {
    logic       r;
    logic       v;
    logic       rdy;
    logic       ev;
    logic [4:0] ech;
    logic       eovf;
  } row_t;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  layer1_serializer_if #(.CHANNELS(CH), .DATA_BITS(DB)) bus ();
  layer1_serializer #(.CHANNELS(CH), .DATA_BITS(DB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errs = 0;
  int checks = 0;
  vec_t mq[$];
  int midx = 0;
  bit movf = 1'b0;
  row_t tbl[12];
  function automatic vec_t pat(input logic [31:0] base);
    vec_t v;
    for (int k = 0; k < CH; k++) v[k] = base + 32'(k + 1) * 32'h0101;
    return v;
  endfunction
  function automatic vec_t rnd();
    vec_t v;
    for (int k = 0; k < CH; k++) v[k] = $urandom;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_check();
    chk("valid_out", 32'(bus.valid_out), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("ch_idx", 32'(bus.ch_idx), 32'(midx));
      chk("data_out", bus.data_out, mq[0][midx]);
    end
    chk("overflow", 32'(bus.overflow), 32'(movf));
`ifdef SER_LAST_EN
    chk("last_out", 32'(bus.last_out), 32'(mq.size() > 0 && midx == CH - 1));
`endif
  endtask
  task automatic cyc(input logic r, input logic v, input logic rdy, input vec_t d);
    rst_n = r;
    bus.valid_in = v;
    bus.ready_in = rdy;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      midx = 0;
      movf = 1'b0;
    end else begin
      if (mq.size() > 0 && rdy) begin
        if (midx == CH - 1) begin
          void'(mq.pop_front());
          midx = 0;
        end else midx++;
      end
      if (v) begin
        if (mq.size() < 2) mq.push_back(d);
        else movf = 1'b1;
      end
    end
    #1;
    model_check();
  endtask
  initial begin
    tbl = '{
      '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0}
    };
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.data_in = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].rdy, pat(32'h0));
      chk("tbl_valid", 32'(bus.valid_out), 32'(tbl[i].ev));
      chk("tbl_ch", 32'(bus.ch_idx), 32'(tbl[i].ech));
      chk("tbl_data", bus.data_out, tbl[i].ev ? (32'(tbl[i].ech) + 32'd1) * 32'h0101 : 32'h0);
      chk("tbl_ovf", 32'(bus.overflow), 32'(tbl[i].eovf));
    end
    cyc(1'b0, 1'b1, 1'b1, pat(32'h0));
    repeat (33) cyc(1'b0, 1'b0, 1'b1, '0);
    chk("single_done", 32'(bus.valid_out), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, pat(32'h100000));
    repeat (5) cyc(1'b0, 1'b0, 1'b1, '0);
    repeat (7) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk("stall_ch", 32'(bus.ch_idx), 32'd5);
      chk("stall_data", bus.data_out, 32'h100000 + 32'd6 * 32'h0101);
    end
    repeat (30) cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, pat(32'h200000));
    cyc(1'b0, 1'b1, 1'b1, pat(32'h300000));
    repeat (66) cyc(1'b0, 1'b0, 1'b1, '0);
    chk("b2b_ovf", 32'(bus.overflow), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, pat(32'h400000));
    cyc(1'b0, 1'b1, 1'b0, pat(32'h500000));
    cyc(1'b0, 1'b1, 1'b0, pat(32'h600000));
    chk("drop_ovf", 32'(bus.overflow), 32'h1);
    repeat (70) cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, pat(32'h700000));
    cyc(1'b0, 1'b1, 1'b1, pat(32'h800000));
    repeat (30) cyc(1'b0, 1'b0, 1'b1, '0);
    chk("pre_free_ch", 32'(bus.ch_idx), 32'd31);
    cyc(1'b0, 1'b1, 1'b1, pat(32'h900000));
    chk("same_free_ovf", 32'(bus.overflow), 32'h0);
    repeat (100) cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, pat(32'hA00000));
    repeat (10) cyc(1'b0, 1'b0, 1'b1, '0);
    chk("pre_rst_ch", 32'(bus.ch_idx), 32'd10);
    cyc(1'b1, 1'b0, 1'b1, '0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_ch", 32'(bus.ch_idx), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    repeat (3000)
      cyc(1'($urandom_range(499) == 0), 1'($urandom_range(23) == 0), 1'($urandom_range(3) != 0), rnd());
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
